// File: rtl/mem_stream_reader.sv
// Read-sweep initiator for the synchronous mem port: streams a wrapping address range
// through a 4-deep output FIFO and performs single-cycle writes while idle.
module mem_stream_reader #(
    parameter int word_size    = 8,
    parameter int address_bits = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [address_bits-1:0] base_add,
    input  logic [address_bits-1:0] last_add,
    output logic [word_size-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    wr_req,
    input  logic [address_bits-1:0] wr_add,
    input  logic [word_size-1:0]    wr_data,
    output logic                    wr_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    EN,
    output logic                    RW,
    output logic [address_bits-1:0] add,
    inout  wire  [word_size-1:0]    data
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    localparam logic [address_bits-1:0] ADD_ONE = {{(address_bits-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [address_bits-1:0] r_left;
    logic                    r_pend;
    logic                    r_drive;
    logic [word_size-1:0]    r_wdata;
    logic [word_size-1:0]    r_fifo [4];
    logic [1:0]              r_wrPtr;
    logic [1:0]              r_rdPtr;
    logic [2:0]              r_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_readOut;
    logic [2:0]              w_countNext;
    logic                    w_canIssue;
    logic                    w_lastOut;

    assign out_valid   = (r_count != 3'd0);
    assign out_data    = r_fifo[r_rdPtr];
    assign data        = r_drive ? r_wdata : {word_size{1'bz}};

    assign w_push      = r_pend;
    assign w_pop       = out_valid & out_ready;
    assign w_readOut   = EN & ~RW;
    assign w_countNext = r_count + {2'b00, w_push} - {2'b00, w_pop};
    // The read the memory samples at this edge lands one edge later, so it must
    // be reserved alongside the post-edge FIFO occupancy before issuing another.
    assign w_canIssue  = ({1'b0, w_countNext} + {3'b000, w_readOut}) < 4'd4;
    assign w_lastOut   = (r_count == 3'd1) & w_pop & ~r_pend & ~w_readOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            EN      <= 1'b0;
            RW      <= 1'b0;
            add     <= '0;
            r_left  <= '0;
            r_pend  <= 1'b0;
            r_drive <= 1'b0;
            r_wdata <= '0;
            wr_ack  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_pend <= w_readOut;
            done   <= 1'b0;
            wr_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    EN      <= 1'b0;
                    RW      <= 1'b0;
                    r_drive <= 1'b0;
                    if (start) begin
                        r_state <= (last_add == base_add) ? DRAIN : READ;
                        EN      <= 1'b1;
                        add     <= base_add;
                        r_left  <= last_add - base_add;
                        busy    <= 1'b1;
                    end else if (wr_req) begin
                        r_state <= WRITE;
                        EN      <= 1'b1;
                        RW      <= 1'b1;
                        add     <= wr_add;
                        r_wdata <= wr_data;
                        r_drive <= 1'b1;
                        wr_ack  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    if (w_canIssue) begin
                        EN     <= 1'b1;
                        add    <= add + ADD_ONE;
                        r_left <= r_left - ADD_ONE;
                        if (r_left == ADD_ONE) begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        EN <= 1'b0;
                    end
                end
                DRAIN: begin
                    EN <= 1'b0;
                    if (w_lastOut) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                WRITE: begin
                    EN      <= 1'b0;
                    RW      <= 1'b0;
                    r_drive <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= data;
                r_wrPtr         <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            r_count <= w_countNext;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: behavioural memory, scoreboard of expected words,
// table of sweep vectors plus hand-written write, collision and reset sequences.
module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base_add = 4'h0;
    logic [3:0] last_add = 4'h0;
    logic       out_ready = 1'b0;
    logic       wr_req = 1'b0;
    logic [3:0] wr_add = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       wr_ack;
    logic       busy;
    logic       done;
    logic       EN;
    logic       RW;
    logic [3:0] add;
    wire  [7:0] dataBus;

    logic [7:0] memArr [16];
    logic       memLoaded = 1'b0;
    logic       memDrive = 1'b0;
    logic [7:0] memOut = 8'h00;
    logic [7:0] refMem [16];
    logic [7:0] expQ [$];

    int total = 0;
    int bad = 0;
    int cycNum = 0;
    int startCyc = 0;
    int enCount = 0;
    int doneCount = 0;
    int wordCount = 0;
    int firstValidCyc = -1;
    int firstXferCyc = -1;
    int lastXferCyc = -1;
    int doneCyc = -1;
    logic prevBusy = 1'b0;
    logic busyAtDone = 1'b0;
    logic busyBeforeDone = 1'b0;

    typedef struct {
        string      name;
        logic [3:0] base;
        logic [3:0] last;
        int         stall;
        int         expWords;
    } vec_t;

    vec_t vecs [4];

    mem_stream_reader #(.word_size(8), .address_bits(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_add  (base_add),
        .last_add  (last_add),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wr_req    (wr_req),
        .wr_add    (wr_add),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .done      (done),
        .EN        (EN),
        .RW        (RW),
        .add       (add),
        .data      (dataBus)
    );

    always #5 clk = ~clk;

    // Memory samples EN/RW at an edge and drives read data for the whole next cycle.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 16; i++) begin
                memArr[i] <= 8'h10 + 8'(i);
            end
            memLoaded <= 1'b1;
        end else if (EN && RW) begin
            memArr[add] <= dataBus;
        end
        memDrive <= EN && !RW;
        memOut   <= memArr[add];
    end

    assign dataBus = memDrive ? memOut : 8'hzz;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Samples the cycle before the coming edge, then advances to the next negedge.
    task automatic cycle();
        logic [7:0] expWord;
        if (EN && !RW) enCount++;
        if (done) begin
            doneCount++;
            doneCyc        = cycNum;
            busyAtDone     = busy;
            busyBeforeDone = prevBusy;
        end
        if (out_valid && firstValidCyc < 0) firstValidCyc = cycNum;
        if (out_valid && out_ready) begin
            wordCount++;
            if (firstXferCyc < 0) firstXferCyc = cycNum;
            lastXferCyc = cycNum;
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL extraWord actual=%0h required=none", out_data);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("streamWord", 32'(out_data), 32'(expWord));
            end
        end
        prevBusy = busy;
        cycNum++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] b, input logic [3:0] l,
                                 input logic wr, input logic [3:0] wa, input logic [7:0] wd,
                                 input logic rdy);
        logic [3:0] a;
        start     = st;
        base_add  = b;
        last_add  = l;
        wr_req    = wr;
        wr_add    = wa;
        wr_data   = wd;
        out_ready = rdy;
        if (st) begin
            startCyc = cycNum;
            a = b;
            for (int k = 0; k < 16; k++) begin
                expQ.push_back(refMem[a]);
                if (a == l) break;
                a = a + 4'h1;
            end
        end else if (wr) begin
            refMem[wa] = wd;
        end
        cycle();
        start  = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic runSweep(input string tag, input logic [3:0] b, input logic [3:0] l,
                            input int stall, input int expWords, input logic alsoWr);
        int en0;
        int d0;
        int w0;
        int waited;
        en0 = enCount;
        d0  = doneCount;
        w0  = wordCount;
        firstValidCyc = -1;
        firstXferCyc  = -1;
        lastXferCyc   = -1;
        doneCyc       = -1;
        applyStimulus(1'b1, b, l, alsoWr, b, 8'h00, (stall == 0));
        checkOutput({tag, ".firstEN"}, 32'(EN), 32'd1);
        checkOutput({tag, ".firstAdd"}, 32'(add), 32'(b));
        checkOutput({tag, ".busyRise"}, 32'(busy), 32'd1);
        if (alsoWr) begin
            checkOutput({tag, ".noWrAck"}, 32'(wr_ack), 32'd0);
            checkOutput({tag, ".readDir"}, 32'(RW), 32'd0);
        end
        for (int i = 0; i < stall; i++) begin
            if (out_valid) checkOutput({tag, ".stallHead"}, 32'(out_data), 32'(expQ[0]));
            cycle();
        end
        if (stall > 0) begin
            checkOutput({tag, ".stallReadsAtMost4"}, 32'(enCount - en0 <= 4), 32'd1);
            checkOutput({tag, ".stallEnLow"}, 32'(EN), 32'd0);
            checkOutput({tag, ".stallNoXfer"}, 32'(wordCount - w0), 32'd0);
            out_ready = 1'b1;
        end
        waited = 0;
        while (doneCount == d0 && waited < 200) begin
            cycle();
            waited++;
        end
        repeat (3) cycle();
        checkOutput({tag, ".doneOnce"}, 32'(doneCount - d0), 32'd1);
        checkOutput({tag, ".words"}, 32'(wordCount - w0), 32'(expWords));
        checkOutput({tag, ".enCycles"}, 32'(enCount - en0), 32'(expWords));
        checkOutput({tag, ".firstValidLat"}, 32'(firstValidCyc - startCyc), 32'd3);
        checkOutput({tag, ".doneAfterLast"}, 32'(doneCyc), 32'(lastXferCyc + 1));
        checkOutput({tag, ".busyFallAtDone"}, {30'd0, busyBeforeDone, busyAtDone}, 32'd2);
        checkOutput({tag, ".scoreboardEmpty"}, 32'(expQ.size()), 32'd0);
        if (stall == 0) begin
            checkOutput({tag, ".backToBack"}, 32'(lastXferCyc - firstXferCyc), 32'(expWords - 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w0;
        int d0;
        int waited;

        vecs[0] = '{"straight", 4'h3, 4'h6, 0, 4};
        vecs[1] = '{"wrap",     4'hE, 4'h1, 0, 4};
        vecs[2] = '{"single",   4'h9, 4'h9, 0, 1};
        vecs[3] = '{"backpres", 4'h0, 4'hF, 8, 16};
        for (int i = 0; i < 16; i++) begin
            refMem[i] = 8'h10 + 8'(i);
        end

        repeat (3) @(negedge clk);
        checkOutput("rst.EN", 32'(EN), 32'd0);
        checkOutput("rst.RW", 32'(RW), 32'd0);
        checkOutput("rst.add", 32'(add), 32'd0);
        checkOutput("rst.outValid", 32'(out_valid), 32'd0);
        checkOutput("rst.outData", 32'(out_data), 32'd0);
        checkOutput("rst.wrAck", 32'(wr_ack), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        for (int v = 0; v < 4; v++) begin
            runSweep(vecs[v].name, vecs[v].base, vecs[v].last, vecs[v].stall, vecs[v].expWords, 1'b0);
        end

        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'hA, 8'hFF, 1'b1);
        checkOutput("wr.EN", 32'(EN), 32'd1);
        checkOutput("wr.RW", 32'(RW), 32'd1);
        checkOutput("wr.add", 32'(add), 32'hA);
        checkOutput("wr.bus", 32'(dataBus), 32'hFF);
        checkOutput("wr.ack", 32'(wr_ack), 32'd1);
        checkOutput("wr.busy", 32'(busy), 32'd1);
        cycle();
        checkOutput("wrAfter.ack", 32'(wr_ack), 32'd0);
        checkOutput("wrAfter.EN", 32'(EN), 32'd0);
        checkOutput("wrAfter.busReleased", 32'(dataBus !== 8'hFF), 32'd1);
        checkOutput("wrAfter.busy", 32'(busy), 32'd0);
        runSweep("wrBack", 4'hA, 4'hA, 0, 1, 1'b0);

        runSweep("startWins", 4'h5, 4'h5, 0, 1, 1'b1);

        w0 = wordCount;
        applyStimulus(1'b1, 4'h0, 4'h7, 1'b0, 4'h0, 8'h00, 1'b1);
        waited = 0;
        while (wordCount - w0 < 2 && waited < 50) begin
            cycle();
            waited++;
        end
        checkOutput("midReset.reachedWord2", 32'(wordCount - w0), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.EN", 32'(EN), 32'd0);
        checkOutput("midReset.add", 32'(add), 32'd0);
        checkOutput("midReset.outValid", 32'(out_valid), 32'd0);
        checkOutput("midReset.outData", 32'(out_data), 32'd0);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.done", 32'(done), 32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = doneCount;
        w0 = wordCount;
        repeat (6) cycle();
        checkOutput("midReset.noDone", 32'(doneCount - d0), 32'd0);
        checkOutput("midReset.noWords", 32'(wordCount - w0), 32'd0);
        runSweep("postReset", 4'h2, 4'h4, 0, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
